// File: rtl/tt_pkg.sv
// Shared definitions for the frontend time-tag source and the backend decoder:
// word field positions, framing pattern and word classification.
package tt_pkg;

  localparam int WORD_W     = 128;
  localparam int PERIOD_W   = 48;
  localparam int N_MOD      = 16;
  localparam int MOD_ID_W   = 4;

  localparam int FRAME_HI   = 127;
  localparam int FRAME_LO   = 123;
  localparam int SINGLE_BIT = 122;
  localparam int ID_HI      = 121;
  localparam int ID_LO      = 118;
  localparam int BLK_HI     = 117;
  localparam int BLK_LO     = 116;
  localparam int CMD_BIT    = 115;
  localparam int RSV_HI     = 114;
  localparam int RSV_LO     = 48;

  localparam logic [4:0] FRAMING = 5'b11111;

  // Clock cycles between consecutive time tags emitted by a frontend module.
  localparam int CLK_PER_TT = 1024;

  typedef enum logic [1:0] {
    TT,
    FWD,
    BAD
  } word_type_e;

endpackage

// File: rtl/tt_word_classify.sv
// Combinational decode of an incoming link word into type, module id and period.
module tt_word_classify
  import tt_pkg::*;
(
  input  logic [FRAME_HI:ID_LO]   word_hi,
  input  logic                    cmd_flag,
  input  logic [RSV_HI:0]         word_lo,
  output word_type_e              word_type,
  output logic [MOD_ID_W-1:0]     mod_id,
  output logic [PERIOD_W-1:0]     period
);

  // The block id field sits between word_hi and cmd_flag; it plays no part in
  // classification, so the top does not route it here.
  always_comb begin
    word_type = BAD;
    mod_id    = word_hi[ID_HI:ID_LO];
    period    = word_lo[PERIOD_W-1:0];
    if (word_hi[FRAME_HI:FRAME_LO] == FRAMING) begin
      if (word_hi[SINGLE_BIT] || cmd_flag) begin
        word_type = FWD;
      end else if (word_lo[RSV_HI:RSV_LO] == '0) begin
        word_type = TT;
      end
    end
  end

endmodule

// File: rtl/time_tag_decoder.sv
// Backend time-tag decoder: consumes time tags to track a per-module period,
// forwards event/command words tagged with that period, counts link errors.
module time_tag_decoder
  import tt_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WORD_W-1:0]    s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WORD_W-1:0]    m_data,
  output logic [PERIOD_W-1:0]  m_period,
  output logic                 m_locked,
  output logic [N_MOD-1:0]     lock,
  output logic [CNT_W-1:0]     frame_err_cnt,
  output logic [CNT_W-1:0]     tt_gap_cnt,
  output logic [31:0]          tt_cnt
);

  word_type_e            word_type;
  logic [MOD_ID_W-1:0]   mod_id;
  logic [PERIOD_W-1:0]   period;
  logic                  accept;

  logic                  m_valid_q, m_valid_d;
  logic [WORD_W-1:0]     m_data_q, m_data_d;
  logic [PERIOD_W-1:0]   m_period_q, m_period_d;
  logic                  m_locked_q, m_locked_d;
  logic [N_MOD-1:0]      lock_q, lock_d;
  logic [PERIOD_W-1:0]   last_q [N_MOD];
  logic [PERIOD_W-1:0]   last_d [N_MOD];
  logic [CNT_W-1:0]      frame_err_q, frame_err_d;
  logic [CNT_W-1:0]      gap_q, gap_d;
  logic [31:0]           tt_cnt_q, tt_cnt_d;

  tt_word_classify u_classify (
    .word_hi   (s_data[FRAME_HI:ID_LO]),
    .cmd_flag  (s_data[CMD_BIT]),
    .word_lo   (s_data[RSV_HI:0]),
    .word_type (word_type),
    .mod_id    (mod_id),
    .period    (period)
  );

  assign s_ready = ~m_valid_q | m_ready;
  assign accept  = s_valid & s_ready;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
    m_valid_d   = m_valid_q & ~m_ready;
    m_data_d    = m_data_q;
    m_period_d  = m_period_q;
    m_locked_d  = m_locked_q;
    lock_d      = lock_q;
    last_d      = last_q;
    frame_err_d = frame_err_q;
    gap_d       = gap_q;
    tt_cnt_d    = tt_cnt_q;

    if (accept) begin
      unique case (word_type)
        BAD: begin
          if (frame_err_q != '1) frame_err_d = frame_err_q + CNT_W'(1);
        end
        TT: begin
          tt_cnt_d = tt_cnt_q + 32'd1;
          // Modulo-2^48 successor, so all-ones followed by zero is continuous.
          if (lock_q[mod_id] && (period != last_q[mod_id] + 48'd1) && (gap_q != '1)) begin
            gap_d = gap_q + CNT_W'(1);
          end
          last_d[mod_id] = period;
          lock_d[mod_id] = 1'b1;
        end
        FWD: begin
          m_valid_d  = 1'b1;
          m_data_d   = s_data;
          m_period_d = last_q[mod_id];
          m_locked_d = lock_q[mod_id];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_period_q  <= '0;
      m_locked_q  <= 1'b0;
      lock_q      <= '0;
      frame_err_q <= '0;
      gap_q       <= '0;
      tt_cnt_q    <= '0;
      // NOTE: the period table is reset (unlike a RAM) because an unlocked module must report period 0.
      for (int i = 0; i < N_MOD; i++) last_q[i] <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_period_q  <= m_period_d;
      m_locked_q  <= m_locked_d;
      lock_q      <= lock_d;
      frame_err_q <= frame_err_d;
      gap_q       <= gap_d;
      tt_cnt_q    <= tt_cnt_d;
      last_q      <= last_d;
    end
  end

  assign m_valid       = m_valid_q;
  assign m_data        = m_data_q;
  assign m_period      = m_period_q;
  assign m_locked      = m_locked_q;
  assign lock          = lock_q;
  assign frame_err_cnt = frame_err_q;
  assign tt_gap_cnt    = gap_q;
  assign tt_cnt        = tt_cnt_q;

endmodule

// File: tb/tb_time_tag_decoder.sv
// Scoreboard bench for time_tag_decoder: directed words, expected forwarded
// words queued at issue time and compared by an independent output monitor.
module tb_time_tag_decoder;
  import tt_pkg::*;

  localparam int CNT_W = 4;

  logic                clk;
  logic                rst_n;
  logic                s_valid;
  logic                s_ready;
  logic [127:0]        s_data;
  logic                m_valid;
  logic                m_ready;
  logic [127:0]        m_data;
  logic [47:0]         m_period;
  logic                m_locked;
  logic [15:0]         lock;
  logic [CNT_W-1:0]    frame_err_cnt;
  logic [CNT_W-1:0]    tt_gap_cnt;
  logic [31:0]         tt_cnt;

  typedef struct packed {
    logic [127:0] data;
    logic [47:0]  period;
    logic         locked;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  time_tag_decoder #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_period      (m_period),
    .m_locked      (m_locked),
    .lock          (lock),
    .frame_err_cnt (frame_err_cnt),
    .tt_gap_cnt    (tt_gap_cnt),
    .tt_cnt        (tt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] tt_w(input logic [3:0] id, input logic [47:0] p);
    return {5'b11111, 1'b0, id, 2'b00, 1'b0, 67'd0, p};
  endfunction

  function automatic logic [127:0] ev_w(input logic [3:0] id, input logic [15:0] tag);
    return {5'b11111, 1'b1, id, 2'b10, 1'b0, 51'd0, tag, 48'hABCD_0000_1234};
  endfunction

  function automatic logic [127:0] cmd_w(input logic [3:0] id);
    return {5'b11111, 1'b0, id, 2'b01, 1'b1, 67'h5A, 48'h0000_0000_0BAD};
  endfunction

  // Output monitor: every handshake on the output must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data %h expected no output", m_data);
      end else begin
        e = sb_q.pop_front();
        check("out_data", m_data, e.data);
        check("out_period", m_period, e.period);
        check("out_locked", m_locked, e.locked);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] w);
    bit took;
    int n;
    took    = 1'b0;
    n       = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!took && n < 50) begin
      @(negedge clk);
      took = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no s_ready expected acceptance of %h", w);
    end
  endtask

  task automatic push(input logic [127:0] d, input logic [47:0] p, input logic l);
    exp_t e;
    e.data   = d;
    e.period = p;
    e.locked = l;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 128'(sb_q.size()), 128'd0);
  endtask

  logic [127:0] w;
  logic [127:0] ev_a;
  logic [127:0] ev_b;
  bit           took;

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    idle(3);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_period", m_period, 0);
    check("rst_m_locked", m_locked, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_lock", lock, 0);
    check("rst_cnts", {frame_err_cnt, tt_gap_cnt, tt_cnt}, 0);
    rst_n = 1'b1;
    idle(2);

    // Continuity on module 3.
    send(tt_w(4'd3, 48'd5));
    send(tt_w(4'd3, 48'd6));
    send(tt_w(4'd3, 48'd7));
    push(ev_w(4'd3, 16'h0001), 48'd7, 1'b1);
    send(ev_w(4'd3, 16'h0001));
    idle(2);
    check("cont_tt_cnt", tt_cnt, 3);
    check("cont_gap", tt_gap_cnt, 0);
    check("cont_lock", lock, 16'h0008);
    drain("cont_drain");

    // Wrap is continuous; a jump is a gap.
    send(tt_w(4'd0, 48'hFFFF_FFFF_FFFF));
    send(tt_w(4'd0, 48'd0));
    idle(1);
    check("wrap_gap", tt_gap_cnt, 0);
    send(tt_w(4'd0, 48'd5));
    idle(1);
    check("jump_gap", tt_gap_cnt, 1);
    check("jump_lock", lock, 16'h0009);
    push(ev_w(4'd0, 16'h0002), 48'd5, 1'b1);
    send(ev_w(4'd0, 16'h0002));

    // Tag immediately followed by a command for the same module.
    push(cmd_w(4'd3), 48'd8, 1'b1);
    send(tt_w(4'd3, 48'd8));
    send(cmd_w(4'd3));
    drain("ttfwd_drain");
    check("ttfwd_tt_cnt", tt_cnt, 7);
    check("ttfwd_gap", tt_gap_cnt, 1);

    // Framing and reserved-bit errors are dropped.
    w = ev_w(4'd2, 16'h0003);
    w[127:123] = 5'b11110;
    send(w);
    idle(3);
    check("frame_err_1", frame_err_cnt, 1);
    check("frame_no_valid", m_valid, 0);
    w = tt_w(4'd5, 48'd10);
    w[60] = 1'b1;
    send(w);
    idle(2);
    check("rsv_err_2", frame_err_cnt, 2);
    check("rsv_tt_cnt", tt_cnt, 7);
    check("rsv_lock", lock, 16'h0009);

    // Unlocked module.
    push(ev_w(4'd9, 16'h0009), 48'd0, 1'b0);
    send(ev_w(4'd9, 16'h0009));
    drain("unlocked_drain");

    // Backpressure: A held, B stalled, then both in order.
    ev_a = ev_w(4'd3, 16'hAAAA);
    ev_b = ev_w(4'd0, 16'hBBBB);
    m_ready = 1'b0;
    push(ev_a, 48'd8, 1'b1);
    send(ev_a);
    check("bp_s_ready", s_ready, 0);
    check("bp_m_valid", m_valid, 1);
    push(ev_b, 48'd5, 1'b1);
    s_valid = 1'b1;
    s_data  = ev_b;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("bp_hold_data", m_data, ev_a);
      check("bp_hold_period", m_period, 48'd8);
    end
    m_ready = 1'b1;
    took = 1'b0;
    for (int n = 0; n < 20 && !took; n++) begin
      @(negedge clk);
      took = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check("bp_b_taken", took, 1);
    drain("bp_drain");

    // Saturation of the framing error counter.
    w = tt_w(4'd1, 48'd1);
    w[127:123] = 5'b00000;
    repeat ((1 << CNT_W) + 3) send(w);
    idle(2);
    check("sat_frame_err", frame_err_cnt, {CNT_W{1'b1}});
    check("sat_tt_cnt", tt_cnt, 7);

    // Reset with a word held in the output register.
    m_ready = 1'b0;
    send(ev_w(4'd9, 16'h0BAD));
    check("mid_held", m_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_m_valid", m_valid, 0);
    check("mid_m_data", m_data, 0);
    check("mid_m_period", m_period, 0);
    check("mid_m_locked", m_locked, 0);
    check("mid_s_ready", s_ready, 1);
    check("mid_lock", lock, 0);
    check("mid_cnts", {frame_err_cnt, tt_gap_cnt, tt_cnt}, 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    idle(4);
    check("final_queue", 128'(sb_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_tag_decoder.md
# time_tag_decoder

Receive-side counterpart of the frontend time-tag source. Accepts the 128-bit word stream from up to 16 frontend modules and splits it by word type:
- Time tags are consumed and used to track a 48-bit period per module.
- Single-event and command words are forwarded downstream, annotated with their module's current period.
- Framing and continuity errors are counted.

Sits in the backend between the link deserialiser/FIFO and the event packer.

## Interface
Parameters:
- `CNT_W`, default 16: width of each saturating error counter.

Ports:
- `clk`: in, 1, system clock.
- `rst_n`: in, 1, asynchronous, active-low reset.
- `s_valid`: in, 1, input word valid.
- `s_ready`: out, 1, input word accepted.
- `s_data`: in, 128, input word.
- `m_valid`: out, 1, output word valid.
- `m_ready`: in, 1, downstream accepts.
- `m_data`: out, 128, forwarded event or command word, unmodified.
- `m_period`: out, 48, period of the word's module at the time of forwarding.
- `m_locked`: out, 1, that module had received at least one time tag.
- `lock`: out, 16, per-module "time tag seen since reset".
- `frame_err_cnt`: out, `CNT_W`, words dropped for bad framing or reserved bits.
- `tt_gap_cnt`: out, `CNT_W`, time tags whose period was not last+1.
- `tt_cnt`: out, 32, time tags accepted (wraps).

## Operation
Word fields:
- [127:123] framing, must be 5'b11111.
- [122] single-event flag.
- [121:118] module id.
- [117:116] block id.
- [115] command flag.
- [114:48] reserved, zero for time tags.
- [47:0] period.

Classification of each accepted word (`s_valid & s_ready`):
- **BAD:** framing ≠ 5'b11111 → dropped; `frame_err_cnt`++.
- **TT:** single=0, cmd=0.
  - If reserved ≠ 0 → BAD.
  - Else consumed, never forwarded; `tt_cnt`++.
  - If `lock[id]` is set and period ≠ `last[id]`+1 (mod 2^48) → `tt_gap_cnt`++.
  - In all TT cases: `last[id]` ← period, `lock[id]` ← 1.
- **FWD:** single=1, or cmd=1 → loaded into the output register with `m_period` = `last[id]` and `m_locked` = `lock[id]`. Period state is unchanged.

Other rules:
- Error counters saturate at all-ones. `tt_cnt` wraps.
- Period arithmetic is modulo 2^48. Tag 0 following 48'hFFFF_FFFF_FFFF is not a gap.
- Per-module state is `last[0:15]` (48 b) and `lock[15:0]`.

## Timing
- One output register; no further internal buffering.
- `s_ready = ~m_valid | m_ready`. This is combinational from `m_valid`/`m_ready` only, never from `s_valid` or `s_data`.
- TT and BAD words are accepted under the same `s_ready` rule. They take no output slot, so `m_valid` clears if the held word was taken that cycle.
- FWD latency: accepted at edge N → `m_valid` high after edge N. `m_data`/`m_period`/`m_locked` are held stable while `m_valid & ~m_ready`.
- A TT for module k, followed next cycle by a FWD for module k: the FWD carries the new period. The lookup uses state after the TT update.
- Stats and `lock` update on the edge that accepts the word.
- Reset (asynchronous assert, synchronous release to `clk`) clears:
  - `m_valid` = 0, `m_data` = 0, `m_period` = 0, `m_locked` = 0.
  - `lock` = 0, `last[*]` = 0.
  - All counters = 0.
  - `s_ready` = 1 after reset.
- Reset mid-transfer discards the held output word.

## Structure
- Shared package `tt_pkg`:
  - Field bit positions, `FRAMING = 5'b11111`, word-type enum {TT, FWD, BAD}.
  - `CLK_PER_TT`, so frontend and backend share one definition.
- Sub-module `tt_word_classify`: combinational decode of `s_data` into type, module id and period.
- Top contains: period/lock state array, counters, output register.

## Test plan
- **Reset:** hold `rst_n`=0 mid-stream. Required: all outputs 0, `s_ready`=1, `lock`=0.
- **Continuity:** module 3 sends tags with period 5, 6, 7, then an event. Required:
  - `tt_cnt`=3, `tt_gap_cnt`=0, `lock`=16'h0008.
  - Event emerges with `m_period`=7, `m_locked`=1, `m_data` unchanged.
- **Gap and wrap:**
  - Module 0 sends tags 48'hFFFF_FFFF_FFFF then 0 → `tt_gap_cnt`=0.
  - Then tag 5 → `tt_gap_cnt`=1, `last[0]`=5.
- **Errors:**
  - Word with framing 5'b11110 → dropped, `frame_err_cnt`=1, no `m_valid`.
  - TT with bit 60 set → `frame_err_cnt`=2.
  - 2^`CNT_W`+3 bad words → counter stuck at all-ones.
- **Backpressure:**
  - Events A, B with `m_ready`=0 → A held stable; `s_ready`=0 after A; B not taken.
  - Release `m_ready` → A then B delivered in order, no loss or duplication.
- **Unlocked forward:** event from module 9 before any module-9 tag → `m_period`=0, `m_locked`=0.
